// File: rtl/fetch_pc_if.sv
// fetch_pc_if: redirect, icache request/response and buffer push signals around fetch_pc_ctrl.
interface fetch_pc_if;
  logic              flush;
  logic [31:0]       flush_pc;
  logic              stall;
  logic              buffer_full;
  logic              icache_req_valid;
  logic              icache_req_ready;
  logic [31:0]       icache_req_pc;
  logic              icache_resp_valid;
  logic [1:0]        bpu_is_branch;
  logic [1:0]        bpu_taken;
  logic [31:0]       bpu_target;
  logic [1:0]        fetch_en;
  logic [1:0][31:0]  fetch_pc;
  modport master (
    input  flush, flush_pc, stall, buffer_full, icache_req_ready, icache_resp_valid,
           bpu_is_branch, bpu_taken, bpu_target,
    output icache_req_valid, icache_req_pc, fetch_en, fetch_pc
  );
  modport slave (
    output flush, flush_pc, stall, buffer_full, icache_req_ready, icache_resp_valid,
           bpu_is_branch, bpu_taken, bpu_target,
    input  icache_req_valid, icache_req_pc, fetch_en, fetch_pc
  );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: fetch PC generator issuing one outstanding icache request and pushing 2-wide groups.
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
  input logic       clk,
  input logic       rst,
  fetch_pc_if.master b
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;
  state_t      state, state_n;
  logic [31:0] pc_q, pc_n, grp_pc_q;
  logic        accept, resp, slot1, tk0, tk1, hold;
  assign b.icache_req_valid = !rst && state == S_REQ && !b.buffer_full && !b.stall;
  assign b.icache_req_pc    = pc_q;
  assign accept = b.icache_req_valid && b.icache_req_ready;
  assign resp   = !rst && b.icache_resp_valid && state != S_REQ;
  assign slot1  = !grp_pc_q[2];
  assign tk0    = b.bpu_is_branch[0] && b.bpu_taken[0];
  assign tk1    = slot1 && b.bpu_is_branch[1] && b.bpu_taken[1];
  assign hold   = b.stall || b.buffer_full;
  assign b.fetch_pc[0] = resp ? grp_pc_q : '0;
  assign b.fetch_pc[1] = resp ? grp_pc_q + 32'd4 : '0;
  always_ff @(posedge clk)
    if (rst) begin
      state    <= S_REQ;
      pc_q     <= RESET_PC;
      grp_pc_q <= '0;
    end else begin
      state <= state_n;
      pc_q  <= pc_n;
      if (accept) grp_pc_q <= pc_q;
    end
  // a taken slot1 implies slot1 is valid, so {slot1,1} already yields 11 for that case
  always_comb begin
    state_n    = state;
    pc_n       = pc_q;
    b.fetch_en = '0;
    if (b.flush) begin
      pc_n    = b.flush_pc;
      state_n = state == S_REQ ? (accept ? S_DROP : S_REQ) : (resp ? S_REQ : S_DROP);
    end else if (state == S_REQ) begin
      state_n = accept ? S_WAIT : S_REQ;
    end else if (resp) begin
      state_n = S_REQ;
      if (state == S_WAIT) begin
        b.fetch_en = hold ? 2'b00 : tk0 ? 2'b01 : {slot1, 1'b1};
        pc_n       = hold ? grp_pc_q : (tk0 || tk1) ? b.bpu_target
                   : grp_pc_q + (slot1 ? 32'd8 : 32'd4);
      end
    end
  end
endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb_fetch_pc_ctrl: directed and randomized checks of fetch_pc_ctrl against a request-level model.
module tb_fetch_pc_ctrl;
  localparam logic [31:0] RESET_PC = 32'h1c00_0000;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  fetch_pc_if ifc();
  fetch_pc_ctrl #(.RESET_PC(RESET_PC)) dut (.clk(clk), .rst(rst), .b(ifc.master));
  int chk = 0, err = 0, mm = 0;
  logic        flush = 0, stall = 0, full = 0, ready = 0;
  logic [31:0] fpc = 0, tgt = 0;
  logic [1:0]  br = 0, tk = 0;
  int          lat = 1;
  logic [31:0] m_pc, m_gpc;
  logic        m_out, m_drop, pend;
  int          cnt;
  logic        o_valid, o_resp, o_acc, ok;
  logic [31:0] o_pc;
  logic [1:0]  o_en;
  logic [63:0] o_fpc;
  logic [98:0] obs, expv, mm_obs, mm_exp;
  // one clock of stimulus; expected outputs come from the outstanding-request model
  task automatic step();
    logic resp, s1, t0, t1, acc, e_valid;
    logic [1:0] e_en;
    @(negedge clk);
    resp = pend && cnt == 0;
    ifc.flush = flush; ifc.flush_pc = fpc; ifc.stall = stall; ifc.buffer_full = full;
    ifc.icache_req_ready = ready; ifc.icache_resp_valid = resp;
    ifc.bpu_is_branch = br; ifc.bpu_taken = tk; ifc.bpu_target = tgt;
    #1;
    o_valid = ifc.icache_req_valid; o_pc = ifc.icache_req_pc;
    o_en = ifc.fetch_en; o_fpc = ifc.fetch_pc; o_resp = resp;
    o_acc = o_valid && ready;
    s1 = (m_gpc % 32'd8) == 0;
    t0 = br[0] && tk[0];
    t1 = s1 && br[1] && tk[1];
    e_valid = !m_out && !full && !stall;
    e_en = (!resp || flush || m_drop || stall || full) ? 2'd0 : t0 ? 2'd1 : s1 ? 2'd3 : 2'd1;
    acc = e_valid && ready;
    expv = {e_valid, m_pc, e_en, resp ? {m_gpc + 32'd4, m_gpc} : 64'd0};
    obs  = {o_valid, o_pc, o_en, o_fpc};
    if (obs !== expv) begin mm++; mm_obs = obs; mm_exp = expv; end
    if (resp) begin
      if (!flush && !m_drop) m_pc = (stall || full) ? m_gpc : (t0 || t1) ? tgt : m_gpc + (s1 ? 32'd8 : 32'd4);
      m_out = 0; m_drop = 0;
    end
    if (acc) begin m_gpc = m_pc; m_out = 1; m_drop = 0; end
    if (flush) begin m_pc = fpc; m_drop = m_out; end
    if (resp) pend = 0; else if (pend) cnt--;
    if (acc) begin pend = 1; cnt = lat - 1; end
  endtask
  task automatic run_until(input bit want_resp, output logic hit);
    hit = 0;
    for (int i = 0; i < 64 && !hit; i++) begin
      step();
      hit = want_resp ? o_resp : o_acc;
    end
  endtask
  task automatic test_reset();
    ifc.flush = 0; ifc.flush_pc = 0; ifc.stall = 0; ifc.buffer_full = 0; ifc.icache_req_ready = 0;
    ifc.icache_resp_valid = 0; ifc.bpu_is_branch = 0; ifc.bpu_taken = 0; ifc.bpu_target = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk++; if (ifc.icache_req_valid !== 1'b0) begin err++; $display("FAIL rst_valid: got %b want 0", ifc.icache_req_valid); end
    chk++; if (ifc.fetch_en !== 2'b00) begin err++; $display("FAIL rst_en: got %b want 00", ifc.fetch_en); end
    chk++; if (ifc.fetch_pc !== 64'd0) begin err++; $display("FAIL rst_fpc: got %h want 0", ifc.fetch_pc); end
    rst = 0;
    m_pc = RESET_PC; m_gpc = 0; m_out = 0; m_drop = 0; pend = 0; cnt = 0;
    #1;
    chk++; if (ifc.icache_req_pc !== RESET_PC || ifc.icache_req_valid !== 1'b1)
      begin err++; $display("FAIL rst_pc: got %h/%b want %h/1", ifc.icache_req_pc, ifc.icache_req_valid, RESET_PC); end
  endtask
  task automatic test_sequential();
    ready = 1; lat = 1;
    for (int i = 0; i < 3; i++) begin
      run_until(0, ok);
      chk++; if (!ok || o_pc !== RESET_PC + 32'(8 * i)) begin err++; $display("FAIL seq_pc%0d: got %h want %h", i, o_pc, RESET_PC + 32'(8 * i)); end
      run_until(1, ok);
      chk++; if (!ok || o_en !== 2'b11) begin err++; $display("FAIL seq_en%0d: got %b want 11", i, o_en); end
    end
    chk++; if (mm != 0) begin err++; $display("FAIL seq_model: %0d cycles, got %h want %h", mm, mm_obs, mm_exp); end
    mm = 0;
  endtask
  task automatic test_flush_idle();
    ready = 0; flush = 1; fpc = 32'h1c00_0104; step(); flush = 0; ready = 1;
    run_until(0, ok);
    chk++; if (!ok || o_pc !== 32'h1c00_0104) begin err++; $display("FAIL idle_pc: got %h want 1c000104", o_pc); end
    run_until(1, ok);
    chk++; if (!ok || o_en !== 2'b01) begin err++; $display("FAIL idle_en: got %b want 01", o_en); end
    run_until(0, ok);
    chk++; if (!ok || o_pc !== 32'h1c00_0108) begin err++; $display("FAIL idle_next: got %h want 1c000108", o_pc); end
    chk++; if (mm != 0) begin err++; $display("FAIL idle_model: %0d cycles, got %h want %h", mm, mm_obs, mm_exp); end
    mm = 0;
  endtask
  task automatic test_bpu_taken();
    br = 2'b01; tk = 2'b01; tgt = 32'h1c00_0400;
    run_until(1, ok);
    chk++; if (!ok || o_en !== 2'b01) begin err++; $display("FAIL bpu_en: got %b want 01", o_en); end
    br = 0; tk = 0;
    run_until(0, ok);
    chk++; if (!ok || o_pc !== 32'h1c00_0400) begin err++; $display("FAIL bpu_pc: got %h want 1c000400", o_pc); end
    chk++; if (mm != 0) begin err++; $display("FAIL bpu_model: %0d cycles, got %h want %h", mm, mm_obs, mm_exp); end
    mm = 0;
  endtask
  task automatic test_flush_wait();
    run_until(1, ok);
    lat = 5;
    run_until(0, ok);
    step();
    flush = 1; fpc = 32'h1c00_0800; step(); flush = 0;
    run_until(1, ok);
    chk++; if (!ok || o_en !== 2'b00) begin err++; $display("FAIL wait_en: got %b want 00", o_en); end
    lat = 1;
    run_until(0, ok);
    chk++; if (!ok || o_pc !== 32'h1c00_0800) begin err++; $display("FAIL wait_pc: got %h want 1c000800", o_pc); end
    chk++; if (mm != 0) begin err++; $display("FAIL wait_model: %0d cycles, got %h want %h", mm, mm_obs, mm_exp); end
    mm = 0;
  endtask
  task automatic test_buffer_full();
    run_until(1, ok);
    ready = 0; flush = 1; fpc = 32'h1c00_0010; step(); flush = 0; ready = 1;
    run_until(0, ok);
    full = 1;
    run_until(1, ok);
    chk++; if (!ok || o_en !== 2'b00) begin err++; $display("FAIL full_en: got %b want 00", o_en); end
    step();
    chk++; if (o_valid !== 1'b0) begin err++; $display("FAIL full_valid: got %b want 0", o_valid); end
    full = 0;
    run_until(0, ok);
    chk++; if (!ok || o_pc !== 32'h1c00_0010) begin err++; $display("FAIL full_replay: got %h want 1c000010", o_pc); end
    chk++; if (mm != 0) begin err++; $display("FAIL full_model: %0d cycles, got %h want %h", mm, mm_obs, mm_exp); end
    mm = 0;
  endtask
  task automatic test_flush_resp_same();
    flush = 1; fpc = 32'h1c00_0200; step(); flush = 0;
    chk++; if (o_resp !== 1'b1 || o_en !== 2'b00) begin err++; $display("FAIL same_en: got resp %b en %b want 1/00", o_resp, o_en); end
    run_until(0, ok);
    chk++; if (!ok || o_pc !== 32'h1c00_0200) begin err++; $display("FAIL same_pc: got %h want 1c000200", o_pc); end
    chk++; if (mm != 0) begin err++; $display("FAIL same_model: %0d cycles, got %h want %h", mm, mm_obs, mm_exp); end
    mm = 0;
  endtask
  task automatic test_wrap();
    run_until(1, ok);
    ready = 0; flush = 1; fpc = 32'hFFFF_FFF8; step(); flush = 0; ready = 1;
    run_until(0, ok);
    chk++; if (!ok || o_pc !== 32'hFFFF_FFF8) begin err++; $display("FAIL wrap_pc: got %h want fffffff8", o_pc); end
    run_until(1, ok);
    chk++; if (!ok || o_en !== 2'b11 || o_fpc !== {32'hFFFF_FFFC, 32'hFFFF_FFF8})
      begin err++; $display("FAIL wrap_grp: got %b %h want 11 fffffffcfffffff8", o_en, o_fpc); end
    run_until(0, ok);
    chk++; if (!ok || o_pc !== 32'h0) begin err++; $display("FAIL wrap_next: got %h want 00000000", o_pc); end
    chk++; if (mm != 0) begin err++; $display("FAIL wrap_model: %0d cycles, got %h want %h", mm, mm_obs, mm_exp); end
    mm = 0;
  endtask
  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      ready = $urandom_range(0, 1) == 1;
      full  = $urandom_range(0, 9) == 0;
      stall = $urandom_range(0, 9) == 0;
      flush = $urandom_range(0, 19) == 0;
      fpc   = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4) : $urandom & 32'hFFFF_FFFC;
      lat   = $urandom_range(1, 4);
      br    = 2'($urandom);
      tk    = 2'($urandom);
      tgt   = $urandom & 32'hFFFF_FFFC;
      step();
      chk++; if (obs !== expv) begin err++; $display("FAIL rand_c%0d: got %h want %h", i, obs, expv); end
    end
    mm = 0;
    flush = 0; full = 0; stall = 0;
  endtask
  initial begin
    test_reset();
    test_sequential();
    test_flush_idle();
    test_bpu_taken();
    test_flush_wait();
    test_buffer_full();
    test_flush_resp_same();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end
endmodule
